// File: rtl/axis_byte_packer.sv
// AXI-Stream byte packer with optional header insert (AXIS_PACK_HDR_EN); 1-cycle s->m latency, +1 beat on FLUSH.
// Single output register; s_ready drops whenever m_valid && !m_ready, so a stalled output holds every m_* stable.
`timescale 1ns/1ps
module axis_byte_packer #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hdr_valid,
  output logic                    hdr_ready,
  input  logic [DATA_WD-1:0]      hdr_data,
  input  logic [DATA_BYTE_WD-1:0] hdr_keep,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WD-1:0]      s_data,
  input  logic [DATA_BYTE_WD-1:0] s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WD-1:0]      m_data,
  output logic [DATA_BYTE_WD-1:0] m_keep,
  output logic                    m_last
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam int TW = BYTE_CNT_WD + 2;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [TW-1:0] FULL_T = TW'(DATA_BYTE_WD);
  localparam logic [CW-1:0] FULL_C = CW'(DATA_BYTE_WD);

  function automatic logic [CW-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] keep_top(input logic [CW-1:0] c);
    logic [DATA_BYTE_WD-1:0] ones;
    ones = '1;
    return ~(ones >> c);
  endfunction

  function automatic logic [DATA_WD-1:0] data_top(input logic [CW-1:0] c);
    logic [DATA_WD-1:0] ones;
    ones = '1;
    return ~(ones >> {c, 3'b000});
  endfunction

  logic [1:0]           state;
  logic [DATA_WD-1:0]   res_data;
  logic [CW-1:0]        res_cnt;

  logic                 hdr_gate;
  logic [CW-1:0]        hdr_cnt;
  logic [DATA_WD-1:0]   hdr_left;
  logic [CW-1:0]        s_cnt;
  logic [DATA_WD-1:0]   s_clean;
  logic [2*DATA_WD-1:0] concat;
  logic [TW-1:0]        total;
  logic [TW-1:0]        remain;
  logic                 emit_full;
  logic                 out_free;
  logic                 s_fire;
  logic                 hdr_take;

`ifdef AXIS_PACK_HDR_EN
  assign hdr_gate  = hdr_valid;
  assign hdr_cnt   = popcnt(hdr_keep);
  assign hdr_left  = hdr_data << {FULL_C - hdr_cnt, 3'b000};
  assign hdr_ready = !rst && (state == IDLE);
`else
  logic unused_hdr;
  assign unused_hdr = ^{hdr_valid, hdr_data, hdr_keep};
  assign hdr_gate  = 1'b0;
  assign hdr_cnt   = '0;
  assign hdr_left  = '0;
  assign hdr_ready = 1'b0;
`endif

  // Bytes beyond keep are zeroed so stale lanes never OR into the residual.
  assign s_cnt     = popcnt(s_keep);
  assign s_clean   = s_data & data_top(s_cnt);
  assign concat    = {res_data, {DATA_WD{1'b0}}} | ({s_clean, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});
  assign total     = TW'(res_cnt) + TW'(s_cnt);
  assign emit_full = total >= FULL_T;
  assign remain    = total - FULL_T;

  assign out_free  = !m_valid || m_ready;
  assign s_ready   = !rst && (state != FLUSH) && out_free && !((state == IDLE) && hdr_gate);
  assign s_fire    = s_valid && s_ready;
  assign hdr_take  = (state == IDLE) && hdr_gate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      res_data <= '0;
      res_cnt  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      m_last   <= 1'b0;
    end else begin
      if (m_ready) m_valid <= 1'b0;
      if (hdr_take) begin
        res_data <= hdr_left;
        res_cnt  <= hdr_cnt;
        state    <= STREAM;
      end else if (state == FLUSH) begin
        if (out_free) begin
          m_valid  <= 1'b1;
          m_data   <= res_data;
          m_keep   <= keep_top(res_cnt);
          m_last   <= 1'b1;
          res_data <= '0;
          res_cnt  <= '0;
          state    <= IDLE;
        end
      end else if (s_fire) begin
        if (emit_full) begin
          m_valid  <= 1'b1;
          m_data   <= concat[2*DATA_WD-1:DATA_WD];
          m_keep   <= '1;
          m_last   <= s_last && (remain == '0);
          res_data <= concat[DATA_WD-1:0];
          res_cnt  <= CW'(remain);
          if (!s_last)           state <= STREAM;
          else if (remain != '0) state <= FLUSH;
          else                   state <= IDLE;
        end else if (s_last) begin
          // A zero-byte tail still produces a keep=0 beat to mark the boundary.
          m_valid  <= 1'b1;
          m_data   <= concat[2*DATA_WD-1:DATA_WD];
          m_keep   <= keep_top(CW'(total));
          m_last   <= 1'b1;
          res_data <= '0;
          res_cnt  <= '0;
          state    <= IDLE;
        end else begin
          res_data <= concat[2*DATA_WD-1:DATA_WD];
          res_cnt  <= CW'(total);
          state    <= STREAM;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench for axis_byte_packer: a byte-queue model predicts each packet's output beats.
`timescale 1ns/1ps
module tb_axis_byte_packer;
  localparam int NB = 4;
`ifdef AXIS_PACK_HDR_EN
  localparam logic HDR_ON = 1'b1;
`else
  localparam logic HDR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_valid = 1'b0, hdr_ready;
  logic [31:0] hdr_data = '0;
  logic [3:0]  hdr_keep = '0;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0;
  logic        m_valid, m_ready = 1'b1, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  always #5 clk = ~clk;

  axis_byte_packer #(.DATA_WD(32)) dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data), .hdr_keep(hdr_keep),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
  );

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] pd [8];
  logic [3:0]  pk [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Packs the first n queued bytes MSB-first into one expected beat.
  function automatic exp_t mk_beat(input logic [7:0] q[$], input int n, input logic l);
    exp_t e;
    e = '0;
    for (int j = 0; j < n; j++) begin
      e.d[31-8*j -: 8] = q[j];
      e.k[3-j] = 1'b1;
    end
    e.l = l;
    return e;
  endfunction

  task automatic model_pkt(input int n, input logic use_hdr, input logic [31:0] hd, input logic [3:0] hk);
    logic [7:0] pend[$];
    logic       emitted;
    int         c;
    pend = {};
    if (HDR_ON && use_hdr) begin
      c = $countones(hk);
      for (int j = c - 1; j >= 0; j--) pend.push_back(hd[8*j +: 8]);
    end
    for (int b = 0; b < n; b++) begin
      c = $countones(pk[b]);
      for (int j = 0; j < c; j++) pend.push_back(pd[b][31-8*j -: 8]);
      emitted = 1'b0;
      if (pend.size() >= NB) begin
        sb.push_back(mk_beat(pend, NB, (b == n - 1) && (pend.size() == NB)));
        repeat (NB) void'(pend.pop_front());
        emitted = 1'b1;
      end
      if (b == n - 1) begin
        if (pend.size() > 0)  sb.push_back(mk_beat(pend, pend.size(), 1'b1));
        else if (!emitted)    sb.push_back(mk_beat(pend, 0, 1'b1));
      end
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last, input logic lat);
    logic ok;
    s_data  = (d & kmask(k)) | ($urandom & ~kmask(k));
    s_keep  = k;
    s_last  = last;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      if (ok) break;
    end
    #1;
    check("s_handshake", 64'(ok), 64'(1));
    s_valid = 1'b0;
    if (lat) check("latency_m_valid", 64'(m_valid), 64'(1));
  endtask

  task automatic run_pkt(input int n, input logic use_hdr, input logic [31:0] hd, input logic [3:0] hk,
                         input logic lat);
    logic ok;
    model_pkt(n, use_hdr, hd, hk);
    if (use_hdr) begin
      hdr_data  = hd;
      hdr_keep  = hk;
      hdr_valid = 1'b1;
      if (HDR_ON) begin
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          ok = hdr_ready;
          @(posedge clk);
          if (ok) break;
        end
        #1;
        check("hdr_handshake", 64'(ok), 64'(1));
        hdr_valid = 1'b0;
      end
    end
    for (int b = 0; b < n; b++) send_beat(pd[b], pk[b], b == n - 1, lat);
    hdr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic stall5();
    logic [37:0] snap;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (m_valid) break;
    end
    check("stall_first_out", 64'(m_valid), 64'(1));
    m_ready = 1'b0;
    snap = {m_valid, m_data, m_keep, m_last};
    repeat (5) begin
      @(negedge clk);
      check("stall_s_ready", 64'(s_ready), 64'(0));
      check("stall_hold", 64'({m_valid, m_data, m_keep, m_last}), 64'(snap));
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
  endtask

  task automatic load_s1();
    pd[0] = 32'h11223344; pk[0] = 4'b1111;
    pd[1] = 32'h55667788; pk[1] = 4'b1111;
    pd[2] = 32'h99AA0000; pk[2] = 4'b1100;
  endtask

  task automatic load_s2();
    pd[0] = 32'h11223344; pk[0] = 4'b1111;
    pd[1] = 32'h55667788; pk[1] = 4'b1111;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_valid && m_ready) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("m_data", 64'(m_data & kmask(e.k)), 64'(e.d));
        check("m_keep", 64'(m_keep), 64'(e.k));
        check("m_last", 64'(m_last), 64'(e.l));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_m_keep_last", 64'({m_keep, m_last}), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_hdr_ready", 64'(hdr_ready), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_s_ready", 64'(s_ready), 64'(1));
    check("idle_hdr_ready", 64'(hdr_ready), 64'(HDR_ON));

    load_s1();
    run_pkt(3, 1'b0, '0, '0, 1'b1);
    drain();

    load_s2();
    run_pkt(2, 1'b1, 32'h0000AABB, 4'b0011, 1'b0);
    drain();

    pd[0] = 32'h11000000; pd[1] = 32'h22000000; pd[2] = 32'h33000000; pd[3] = 32'h44000000;
    for (int i = 0; i < 4; i++) pk[i] = 4'b1000;
    run_pkt(4, 1'b0, '0, '0, 1'b0);
    drain();

    load_s2();
    fork
      run_pkt(2, 1'b1, 32'h0000AABB, 4'b0011, 1'b0);
      stall5();
    join
    drain();

    pd[0] = 32'h0; pk[0] = 4'b0000;
    run_pkt(1, 1'b0, '0, '0, 1'b0);
    drain();
    check("zero_pkt_back_idle_hdr_ready", 64'(hdr_ready), 64'(HDR_ON));

    // Header presented while idle: ignored entirely when header insertion is compiled out.
    hdr_valid = 1'b1; hdr_data = 32'h0000CCDD; hdr_keep = 4'b0011;
    repeat (3) begin
      @(negedge clk);
      check("idle_hdr_ready_hold", 64'(hdr_ready), 64'(HDR_ON));
    end
    @(posedge clk);
    #1;
    hdr_valid = 1'b0;
    if (HDR_ON) begin
      pd[0] = 32'hEE000000; pk[0] = 4'b1000;
      model_pkt(1, 1'b1, 32'h0000CCDD, 4'b0011);
      send_beat(pd[0], pk[0], 1'b1, 1'b0);
      drain();
    end

    // Park the block in FLUSH behind a stalled output, then reset asynchronously.
    m_ready = 1'b0;
    pd[0] = 32'hAABB0000; pk[0] = 4'b1100;
    pd[1] = 32'hCCDDEE00; pk[1] = 4'b1110;
    run_pkt(2, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    check("flush_m_valid", 64'(m_valid), 64'(1));
    check("flush_s_ready", 64'(s_ready), 64'(0));
    check("flush_hdr_ready", 64'(hdr_ready), 64'(0));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_m_valid", 64'(m_valid), 64'(0));
    check("async_rst_keep_last", 64'({m_keep, m_last}), 64'(0));
    check("async_rst_s_ready", 64'(s_ready), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    load_s1();
    run_pkt(3, 1'b0, '0, '0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
